// File: rtl/data_memory_if.sv
// Bus bundle for the data memory: one write port and one independent
// combinational read port.
interface data_memory_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              we;
    logic [15:0]       w_data;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;

    // The core drives writes and the read address and receives the read byte.
    modport master (
        output we,
        output w_data,
        output w_addr,
        output r_addr,
        input  r_data
    );

    // The memory receives the write strobe, data and addresses and returns the read byte.
    modport slave (
        input  we,
        input  w_data,
        input  w_addr,
        input  r_addr,
        output r_data
    );
endinterface

// File: rtl/data_memory.sv
// Byte-wide data store for the matrix-multiply core: 256 x 8 registers,
// one synchronous write per clock (low byte of the 16-bit bus), independent
// combinational read, and an asynchronous clear of the whole array.
module data_memory #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    data_memory_if.slave bus
);
    logic [7:0] mem [DEPTH];

    // Clear the whole array while reset is low; otherwise store the low byte on an enabled write.
    // An unknown write enable takes the else-path of the if and leaves the array untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (bus.we) begin
            mem[bus.w_addr] <= bus.w_data[7:0];
        end
    end

    // Read port: no enable, no write bypass; reflects the array state directly.
    always_comb begin
        bus.r_data = mem[bus.r_addr];
    end
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a vector table for write/read traffic plus
// hand-written sequences for reset, same-address timing and port independence.
module tb_data_memory;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    data_memory_if #(.ADDR_W(8)) bus ();

    data_memory #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [15:0] w_data;
        logic [7:0]  w_addr;
        logic [7:0]  r_addr;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", name, act, exp);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.we     = 1'b0;
        bus.w_data = '0;
        bus.w_addr = '0;
        bus.r_addr = '0;
        rst_n      = 1'b1;

        vecs[0] = '{"wr30",      1'b1, 16'd15,    8'd30,  8'd30,  8'd15};
        vecs[1] = '{"wr31",      1'b1, 16'd16,    8'd31,  8'd31,  8'd16};
        vecs[2] = '{"wr32",      1'b1, 16'd17,    8'd32,  8'd32,  8'd17};
        vecs[3] = '{"keep30",    1'b0, 16'h0000,  8'd0,   8'd30,  8'd15};
        vecs[4] = '{"upper_ign", 1'b1, 16'hABCD,  8'd7,   8'd7,   8'hCD};
        vecs[5] = '{"we0_a",     1'b0, 16'h00FF,  8'd30,  8'd30,  8'd15};
        vecs[6] = '{"we0_b",     1'b0, 16'h00FF,  8'd30,  8'd30,  8'd15};
        vecs[7] = '{"we0_c",     1'b0, 16'h00FF,  8'd30,  8'd30,  8'd15};
        vecs[8] = '{"rd31",      1'b0, 16'h0000,  8'd0,   8'd31,  8'd16};
        vecs[9] = '{"rd32",      1'b0, 16'h0000,  8'd0,   8'd32,  8'd17};

        // Reset pulse, then sweep read addresses with no clocked writes.
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        foreach (vecs[i]) begin end
        begin
            logic [7:0] sweep [5];
            sweep = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd255};
            for (int i = 0; i < 5; i++) begin
                bus.r_addr = sweep[i];
                #1;
                check($sformatf("rst_rd%0d", sweep[i]), bus.r_data, 8'h00);
            end
        end

        // Table: drive on falling edge, check just after the rising edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.we     = vecs[i].we;
            bus.w_data = vecs[i].w_data;
            bus.w_addr = vecs[i].w_addr;
            bus.r_addr = vecs[i].r_addr;
            @(posedge clk);
            #1;
            check(vecs[i].name, bus.r_data, vecs[i].exp);
        end

        // Same address: old byte before the edge, new byte after it.
        @(negedge clk);
        bus.we     = 1'b1;
        bus.w_data = 16'h1133;
        bus.w_addr = 8'd40;
        bus.r_addr = 8'd40;
        #1;
        check("same_pre", bus.r_data, 8'h00);
        @(posedge clk);
        #1;
        check("same_post", bus.r_data, 8'h33);

        // Independent ports: write 100 while reading 30, then move the read address with no edge.
        @(negedge clk);
        bus.we     = 1'b1;
        bus.w_data = 16'h005A;
        bus.w_addr = 8'd100;
        bus.r_addr = 8'd30;
        @(posedge clk);
        #1;
        check("indep_hold30", bus.r_data, 8'd15);
        bus.we     = 1'b0;
        bus.r_addr = 8'd100;
        #1;
        check("indep_rd100", bus.r_data, 8'h5A);

        // Back-to-back writes on consecutive edges.
        @(negedge clk);
        bus.we = 1'b1; bus.w_data = 16'h0011; bus.w_addr = 8'd200;
        @(negedge clk);
        bus.w_data = 16'h0022; bus.w_addr = 8'd201;
        @(negedge clk);
        bus.we = 1'b0;
        bus.r_addr = 8'd200;
        #1;
        check("b2b_200", bus.r_data, 8'h11);
        bus.r_addr = 8'd201;
        #1;
        check("b2b_201", bus.r_data, 8'h22);

        // Asynchronous reset between edges clears everything immediately.
        bus.r_addr = 8'd30;
        #1;
        check("pre_rst30", bus.r_data, 8'd15);
        rst_n = 1'b0;
        #1;
        check("arst_rd30", bus.r_data, 8'h00);
        bus.r_addr = 8'd31;
        #1;
        check("arst_rd31", bus.r_data, 8'h00);
        bus.r_addr = 8'd32;
        #1;
        check("arst_rd32", bus.r_data, 8'h00);
        bus.r_addr = 8'd100;
        #1;
        check("arst_rd100", bus.r_data, 8'h00);

        // Write edge during reset is dropped.
        @(negedge clk);
        bus.we     = 1'b1;
        bus.w_data = 16'h0077;
        bus.w_addr = 8'd50;
        bus.r_addr = 8'd50;
        @(posedge clk);
        #1;
        check("rst_wr_drop", bus.r_data, 8'h00);

        // Release reset with the write still pending; first edge with rst_n high writes.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_pre", bus.r_data, 8'h00);
        @(posedge clk);
        #1;
        check("rel_first_wr", bus.r_data, 8'h77);
        bus.we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
